// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: synchronizes and debounces a ripple-counter output, turning each accepted
// count change into a modulo delta. Define RCS_STEP_CHECK_EN to flag and drop oversized steps.
module ripple_count_sampler #(
  parameter int CNT_W         = 3,
  parameter int ACC_W         = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             clear,
  output logic [CNT_W:0]   delta,
  output logic             delta_valid,
  input  logic             delta_ready,
  output logic [ACC_W-1:0] total,
  output logic             src_wrap,
  output logic             overflow,
  output logic             step_err
);

  typedef enum logic {TRACK, LOCKED} FilterState;

  localparam logic [3:0]     STAB_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0]     STAB_MAX  = 4'(STABLE_CYCLES);
  localparam logic [CNT_W:0] DELTA_MAX = '1;

  logic [CNT_W-1:0] r_s1;
  logic [CNT_W-1:0] r_s2;
  logic [CNT_W-1:0] r_cand;
  logic [3:0]       r_stab;
  FilterState       r_state;
  logic             r_accPulse;
  logic [CNT_W-1:0] r_accVal;
  logic [CNT_W-1:0] r_lastAcc;
  logic [CNT_W:0]   r_delta;
  logic             r_deltaValid;
  logic [ACC_W-1:0] r_total;
  logic             r_srcWrap;
  logic             r_overflow;

  logic [CNT_W-1:0] w_d;
  logic             w_stepBad;
  logic             w_use;
  logic             w_handshake;
  logic [CNT_W+1:0] w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= cnt_in;
      r_s2 <= r_s1;
    end
  end

  // Accepts are registered here, so the delta/total stage sees them one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TRACK;
      r_cand     <= '0;
      r_stab     <= '0;
      r_accPulse <= 1'b0;
      r_accVal   <= '0;
    end else begin
      r_accPulse <= 1'b0;
      case (r_state)
        TRACK: begin
          if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_stab <= 4'd1;
          end else begin
            if (r_stab < STAB_MAX) r_stab <= r_stab + 4'd1;
            if (r_stab >= STAB_LAST) begin
              r_accPulse <= 1'b1;
              r_accVal   <= r_cand;
              r_state    <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (r_s2 != r_cand) begin
            r_cand  <= r_s2;
            r_stab  <= 4'd1;
            r_state <= TRACK;
          end
        end
        default: r_state <= TRACK;
      endcase
    end
  end

  assign w_d = r_accVal - r_lastAcc;

`ifdef RCS_STEP_CHECK_EN
  localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(1 << (CNT_W - 1));
  logic r_stepErr;

  assign w_stepBad = r_accPulse && (w_d > STEP_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_stepErr <= 1'b0;
    else if (clear)     r_stepErr <= 1'b0;
    else if (w_stepBad) r_stepErr <= 1'b1;
  end

  assign step_err = r_stepErr;
`else
  assign w_stepBad = 1'b0;
  assign step_err  = 1'b0;
`endif

  assign w_use       = r_accPulse && (w_d != '0) && !w_stepBad;
  assign w_handshake = r_deltaValid && delta_ready;
  assign w_sum       = {1'b0, r_delta} + {2'b00, w_d};

  // Reaching the all-ones pending value counts as saturation and sets overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastAcc    <= '0;
      r_delta      <= '0;
      r_deltaValid <= 1'b0;
      r_total      <= '0;
      r_srcWrap    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_srcWrap <= 1'b0;
      if (r_accPulse) r_lastAcc <= r_accVal;
      if (clear) begin
        r_total      <= '0;
        r_delta      <= '0;
        r_deltaValid <= 1'b0;
        r_overflow   <= 1'b0;
      end else begin
        if (r_accPulse && (r_accVal < r_lastAcc)) r_srcWrap <= 1'b1;
        if (w_use) r_total <= r_total + ACC_W'(w_d);
        if (w_use && w_handshake) begin
          r_delta      <= {1'b0, w_d};
          r_deltaValid <= 1'b1;
        end else if (w_use) begin
          if (w_sum >= {1'b0, DELTA_MAX}) begin
            r_delta    <= DELTA_MAX;
            r_overflow <= 1'b1;
          end else begin
            r_delta <= w_sum[CNT_W:0];
          end
          r_deltaValid <= 1'b1;
        end else if (w_handshake) begin
          r_delta      <= '0;
          r_deltaValid <= 1'b0;
        end
      end
    end
  end

  assign delta       = r_delta;
  assign delta_valid = r_deltaValid;
  assign total       = r_total;
  assign src_wrap    = r_srcWrap;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb_ripple_count_sampler: directed and randomized runs of ripple-count values, checked every edge
// against a run-level reference model (a held value is accepted if it lasts STABLE_CYCLES samples).
module tb_ripple_count_sampler;

  localparam int CNT_W         = 3;
  localparam int ACC_W         = 16;
  localparam int STABLE_CYCLES = 2;
  localparam int CNT_MOD       = 1 << CNT_W;
  localparam int DMAX          = (1 << (CNT_W + 1)) - 1;

  typedef struct {
    int edgeNo;
    int value;
  } AcceptEvent;

  logic             clk;
  logic             rstN;
  logic [CNT_W-1:0] cntIn;
  logic             tbClear;
  logic             tbReady;
  logic [CNT_W:0]   delta;
  logic             deltaValid;
  logic [ACC_W-1:0] total;
  logic             srcWrap;
  logic             overflow;
  logic             stepErr;

  AcceptEvent schedQ[$];
  int         edgeCount;
  int         checks;
  int         failures;
  int         wrapCount;
  int         prevCnt;

  int mDelta;
  int mTotal;
  int mLast;
  bit mValid;
  bit mWrap;
  bit mOverflow;
  bit mStepErr;

  ripple_count_sampler #(
    .CNT_W(CNT_W),
    .ACC_W(ACC_W),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rstN),
    .cnt_in(cntIn),
    .clear(tbClear),
    .delta(delta),
    .delta_valid(deltaValid),
    .delta_ready(tbReady),
    .total(total),
    .src_wrap(srcWrap),
    .overflow(overflow),
    .step_err(stepErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mDelta    = 0;
    mTotal    = 0;
    mLast     = 0;
    mValid    = 0;
    mWrap     = 0;
    mOverflow = 0;
    mStepErr  = 0;
    schedQ.delete();
  endtask

  task automatic modelEdge();
    bit hs;
    bit acc;
    bit useD;
    int v;
    int d;
    int old;
    int sum;
    hs   = mValid && tbReady;
    acc  = 0;
    useD = 0;
    v    = 0;
    d    = 0;
    mWrap = 0;
    if (schedQ.size() > 0 && schedQ[0].edgeNo == edgeCount) begin
      acc = 1;
      v   = schedQ[0].value;
      void'(schedQ.pop_front());
    end
    if (acc) begin
      d     = (v - mLast) & (CNT_MOD - 1);
      old   = mLast;
      mLast = v;
      if (!tbClear && d != 0) begin
        if (v < old) mWrap = 1;
`ifdef RCS_STEP_CHECK_EN
        if (d > CNT_MOD / 2) mStepErr = 1;
        else useD = 1;
`else
        useD = 1;
`endif
      end
    end
    if (tbClear) begin
      mTotal    = 0;
      mDelta    = 0;
      mOverflow = 0;
      mStepErr  = 0;
    end else begin
      if (useD) mTotal = (mTotal + d) % (1 << ACC_W);
      if (useD && hs) begin
        mDelta = d;
      end else if (useD) begin
        sum = mDelta + d;
        if (sum >= DMAX) begin
          mDelta    = DMAX;
          mOverflow = 1;
        end else begin
          mDelta = sum;
        end
      end else if (hs) begin
        mDelta = 0;
      end
    end
    mValid = (mDelta != 0);
  endtask

  task automatic checkOutput(input string tag);
    assert (delta === (CNT_W+1)'(mDelta)) else begin
      failures++;
      $error("[TB] FAIL %s delta got=%0d exp=%0d", tag, delta, mDelta);
    end
    checks++;
    assert (deltaValid === mValid) else begin
      failures++;
      $error("[TB] FAIL %s delta_valid got=%0b exp=%0b", tag, deltaValid, mValid);
    end
    checks++;
    assert (total === ACC_W'(mTotal)) else begin
      failures++;
      $error("[TB] FAIL %s total got=%0d exp=%0d", tag, total, mTotal);
    end
    checks++;
    assert (srcWrap === mWrap) else begin
      failures++;
      $error("[TB] FAIL %s src_wrap got=%0b exp=%0b", tag, srcWrap, mWrap);
    end
    checks++;
    assert (overflow === mOverflow) else begin
      failures++;
      $error("[TB] FAIL %s overflow got=%0b exp=%0b", tag, overflow, mOverflow);
    end
    checks++;
    assert (stepErr === mStepErr) else begin
      failures++;
      $error("[TB] FAIL %s step_err got=%0b exp=%0b", tag, stepErr, mStepErr);
    end
    checks++;
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s got=%0d exp=%0d", tag, observed, expected);
    end
    checks++;
  endtask

  task automatic step();
    @(posedge clk);
    edgeCount++;
    modelEdge();
    #1;
    if (srcWrap === 1'b1) wrapCount++;
    checkOutput("edge");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // readyMode: 0 hold current ready, 1 random per cycle; clearRate 0 disables random clears
  task automatic applyStimulus(input int value, input int hold, input int readyMode,
                               input int clearRate);
    cntIn = CNT_W'(value);
    if (value != prevCnt && hold >= STABLE_CYCLES)
      schedQ.push_back('{edgeNo: edgeCount + 3 + STABLE_CYCLES, value: value});
    prevCnt = value;
    for (int i = 0; i < hold; i++) begin
      if (readyMode == 1) tbReady = 1'($urandom_range(0, 1));
      tbClear = (clearRate > 0) && ($urandom_range(1, clearRate) == 1);
      step();
    end
    tbClear = 1'b0;
  endtask

  task automatic doReset();
    rstN  = 1'b0;
    cntIn = '0;
    #2;
    modelReset();
    prevCnt = 0;
    checkOutput("async_reset");
    #2;
    rstN = 1'b1;
  endtask

  initial begin
    int v;
    int hold;
    int mode;
    checks    = 0;
    failures  = 0;
    edgeCount = 0;
    wrapCount = 0;
    prevCnt   = 0;
    tbClear   = 1'b0;
    tbReady   = 1'b1;
    cntIn     = '0;
    rstN      = 1'b1;
    modelReset();
    #1;
    doReset();

    $display("[TB] reset release with idle input");
    idle(20);
    checkValue("idle_total", int'(total), 0);
    checkValue("idle_wraps", wrapCount, 0);

    $display("[TB] single steps 1,2,3");
    applyStimulus(1, 10, 0, 0);
    applyStimulus(2, 10, 0, 0);
    applyStimulus(3, 10, 0, 0);
    checkValue("steps_total", int'(total), 3);

    $display("[TB] glitch then step to 4");
    applyStimulus(2, 1, 0, 0);
    applyStimulus(4, 10, 0, 0);
    checkValue("glitch_total", int'(total), 4);

    $display("[TB] wrap 6,7,0,1");
    wrapCount = 0;
    applyStimulus(6, 10, 0, 0);
    applyStimulus(7, 10, 0, 0);
    applyStimulus(0, 10, 0, 0);
    applyStimulus(1, 10, 0, 0);
    checkValue("wrap_pulses", wrapCount, 1);
    checkValue("wrap_total", int'(total), 9);

    $display("[TB] backpressure saturation");
    applyStimulus(0, 10, 0, 0);
    tbReady = 1'b0;
    for (int k = 1; k <= 15; k++) applyStimulus(k % CNT_MOD, 4, 0, 0);
    idle(6);
    checkValue("sat_delta", int'(delta), 15);
    checkValue("sat_overflow", int'(overflow), 1);
    checkValue("sat_total", int'(total), 31);
    tbReady = 1'b1;
    step();
    checkValue("drain_delta", int'(delta), 0);
    tbClear = 1'b1;
    step();
    tbClear = 1'b0;
    checkValue("clear_overflow", int'(overflow), 0);
    checkValue("clear_total", int'(total), 0);

    $display("[TB] reset during pending handshake");
    tbReady = 1'b0;
    applyStimulus(3, 6, 0, 0);
    checkValue("pend_delta", int'(delta), 4);
    tbReady = 1'b1;
    doReset();
    idle(10);
    checkValue("post_reset_valid", int'(deltaValid), 0);
    tbReady = 1'b0;
    applyStimulus(2, 8, 0, 0);
    checkValue("post_reset_delta", int'(delta), 2);

    $display("[TB] large step 0 to 6 then 7");
    doReset();
    idle(4);
    applyStimulus(6, 8, 0, 0);
`ifdef RCS_STEP_CHECK_EN
    checkValue("jump_step_err", int'(stepErr), 1);
    checkValue("jump_total", int'(total), 0);
    tbReady = 1'b1;
    step();
    tbReady = 1'b0;
    applyStimulus(7, 8, 0, 0);
    checkValue("after_jump_delta", int'(delta), 1);
`else
    checkValue("jump_step_err", int'(stepErr), 0);
    checkValue("jump_total", int'(total), 6);
    tbReady = 1'b1;
    step();
    tbReady = 1'b0;
    applyStimulus(7, 8, 0, 0);
    checkValue("after_jump_delta", int'(delta), 1);
`endif

    $display("[TB] randomized runs");
    for (int r = 0; r < 250; r++) begin
      v    = (prevCnt + int'($urandom_range(1, CNT_MOD - 1))) % CNT_MOD;
      hold = int'($urandom_range(1, 6));
      mode = int'($urandom_range(0, 2));
      if (mode == 0) tbReady = 1'b0;
      if (mode == 2) tbReady = 1'b1;
      applyStimulus(v, hold, (mode == 1) ? 1 : 0, 50);
      if (r == 125) doReset();
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ripple_count_sampler.md
Name: ripple_count_sampler

Overview:
- Sits directly downstream of the 3-bit asynchronous ripple counter and consumes its count output.
- Brings the count into the system clock domain and filters out transient codes caused by ripple skew.
- Converts each accepted count change into a modulo delta, accumulates it into a wide running total, and offers pending deltas over a valid/ready interface.

Parameters:
- CNT_W, 3: width of the ripple count input.
- ACC_W, 16: width of the running total.
- STABLE_CYCLES, 2: consecutive identical synchronized samples required before a value is accepted. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cnt_in  in  CNT_W  ripple counter output; asynchronous to clk, and bits may change non-simultaneously.
- clear  in  1  synchronous clear of total, pending delta and sticky flags.
- delta  out  CNT_W+1  accumulated, not-yet-consumed count delta.
- delta_valid  out  1  high when delta != 0.
- delta_ready  in  1  consumer accepts delta when delta_valid && delta_ready.
- total  out  ACC_W  running sum of all accepted deltas, modulo 2^ACC_W.
- src_wrap  out  1  one-cycle pulse when the accepted value is numerically below the previous accepted value.
- overflow  out  1  sticky; set when the pending delta saturates.
- step_err  out  1  sticky step-error flag; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous), all of the following are 0:
  - sync stages s1 and s2, candidate cand, stability counter stab, last accepted value last_acc;
  - outputs delta, delta_valid, total, src_wrap, overflow, step_err.
  - last_acc = 0 matches the ripple counter's reset value, so no spurious delta is produced on release.
- Synchronizer: two flops per bit, s1 <= cnt_in, s2 <= s1. No other logic touches cnt_in.
- Stability filter FSM, two states:
  - TRACK:
    - if s2 != cand: cand <= s2, stab <= 1;
    - else if stab < STABLE_CYCLES: stab <= stab + 1;
    - an accept event fires in the cycle where s2 == cand and stab == STABLE_CYCLES - 1; then go to LOCKED.
  - LOCKED: stays there while s2 == cand, with no repeated accepts. When s2 != cand, go to TRACK with cand <= s2, stab <= 1.
- Accept event:
  - d = (cand - last_acc) mod 2^CNT_W; last_acc <= cand.
  - If d == 0, nothing else happens.
  - Otherwise total <= total + d (wraps modulo 2^ACC_W, no flag).
  - src_wrap pulses for exactly 1 cycle if cand < last_acc.
- Pending delta, width CNT_W+1:
  - handshake this cycle, no accept: delta <= 0;
  - handshake and accept in the same cycle: delta <= d;
  - accept, no handshake: delta <= delta + d, saturating at 2^(CNT_W+1) - 1. If saturation occurs, overflow <= 1.
  - delta never drops without a handshake or clear.
- Latency: a cnt_in value held stable from its first sampling edge E produces an accept on edge E + 1 + STABLE_CYCLES. delta_valid and total update on the following edge, i.e. 4 edges after E at default parameters.
- clear (synchronous):
  - total, delta, overflow, step_err <= 0;
  - an accept in the same cycle still updates last_acc, but its delta is discarded and src_wrap is suppressed;
  - sync stages and filter state are unaffected.
- Reset asserted mid-handshake: pending delta is lost, and the consumer must not see delta_valid again until a new accept.
- Registered outputs: no combinational path from cnt_in or delta_ready to any output.

Optional Feature:
- Macro: RCS_STEP_CHECK_EN.
- Defined:
  - any accepted d > 2^(CNT_W-1) (greater than 4 at default) is treated as a missed or illegal step;
  - step_err <= 1 (sticky until clear or reset); d is discarded, so total and delta are unchanged;
  - last_acc is still updated to cand.
- Not defined:
  - step_err is tied to 0;
  - every accepted d is used regardless of size.

Test Plan:
- Reset release with cnt_in=0 for 20 cycles -> delta_valid=0, total=0, src_wrap never pulses.
- cnt_in steps 0->1->2->3, each held 10 cycles, delta_ready=1 -> three delta_valid pulses with delta=1 each. total=3; the first pulse appears 4 edges after the first sampling of value 1.
- Glitch: cnt_in 3->2 for 1 clk, then 3->4 held; delta_ready=1 -> only one accept, delta=1, total +1, no extra pulse.
- Wrap: cnt_in counts 6,7,0,1 with delta_ready=1 -> src_wrap pulses once, on the 0 accept; total increases by 3 overall.
- Backpressure: delta_ready=0 while cnt_in advances 0..7..0..7 (15 steps) -> delta saturates at 15 and overflow=1. Raising delta_ready gives one handshake, then delta=0; asserting clear then gives overflow=0 and total=0.
- With RCS_STEP_CHECK_EN: cnt_in jumps 0->6 -> step_err=1, total unchanged. A subsequent 6->7 gives delta=1.
